// File: rtl/exu_muldiv_if.sv
// ID/EX-to-muldiv bus and the muldiv result/stall outputs, bundled as one interface.
// The unit (slave) samples the instruction fields and drives the result,
// stall and debug fields. The pipeline side (master) does the opposite.
// Handshake: there is no valid/ready pair. The unit accepts an M-op that is
// present on instr_i_idu2exu_muldiv in any cycle where busy_o is 0. It asserts
// hold_flag_o_muldiv_ctrl in that same cycle, and the pipeline then presents
// NOPs until the write-back cycle.
interface exu_muldiv_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instr_i_idu2exu_muldiv;
  logic [XLEN-1:0] op1_data_i_idu2exu_muldiv;
  logic [XLEN-1:0] op2_data_i_idu2exu_muldiv;
  logic [4:0]      rd_addr_i_idu2exu_muldiv;
  logic            hold_flag_o_muldiv_ctrl;
  logic [XLEN-1:0] rd_data_o_muldiv_regs;
  logic [4:0]      rd_addr_o_muldiv_regs;
  logic            reg_wen_o_muldiv_regs;
  logic            busy_o;
  logic [1:0]      dbg_state;

  modport slave (
    input  instr_i_idu2exu_muldiv, op1_data_i_idu2exu_muldiv,
           op2_data_i_idu2exu_muldiv, rd_addr_i_idu2exu_muldiv,
    output hold_flag_o_muldiv_ctrl, rd_data_o_muldiv_regs,
           rd_addr_o_muldiv_regs, reg_wen_o_muldiv_regs, busy_o, dbg_state
  );

  modport master (
    output instr_i_idu2exu_muldiv, op1_data_i_idu2exu_muldiv,
           op2_data_i_idu2exu_muldiv, rd_addr_i_idu2exu_muldiv,
    input  hold_flag_o_muldiv_ctrl, rd_data_o_muldiv_regs,
           rd_addr_o_muldiv_regs, reg_wen_o_muldiv_regs, busy_o, dbg_state
  );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// The unit uses radix-2 shift-add multiplication and restoring division on
// operand magnitudes. A FIXUP cycle applies the sign and selects the result,
// and a DONE cycle writes the result back.
// Optional macro MULDIV_EARLY_OUT_EN lets the multiply loop exit to FIXUP
// once the remaining multiplier bits are zero.
// rstn is a synchronous, active-high reset.
module exu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  exu_muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_neg_q;    // negate product / quotient in FIXUP
  logic              r_neg_r;    // negate remainder in FIXUP
  logic [2*XLEN-1:0] r_prod;     // MUL: product accumulator; DIV: {remainder, quotient}
  logic [2*XLEN-1:0] r_mcand;    // MUL: shifted multiplicand; DIV: divisor in low half
  logic [XLEN-1:0]   r_mplier;   // MUL: multiplier, shifted right each iteration
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_rd_data;
  logic [4:0]        r_rd_addr;

  // Decode of the incoming instruction
  logic [2:0]      w_funct3;
  logic            w_is_mop;
  logic            w_accept;
  logic            w_op1_signed;
  logic            w_op2_signed;
  logic            w_op1_neg;
  logic            w_op2_neg;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_op1_mag;
  logic [XLEN-1:0] w_op2_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_special_res;

  assign w_funct3     = bus.instr_i_idu2exu_muldiv[14:12];
  assign w_is_mop     = (bus.instr_i_idu2exu_muldiv[6:0] == 7'b0110011) &&
                        (bus.instr_i_idu2exu_muldiv[31:25] == 7'b0000001);
  assign w_accept     = (r_state == S_IDLE) && w_is_mop;
  assign w_op1        = bus.op1_data_i_idu2exu_muldiv;
  assign w_op2        = bus.op2_data_i_idu2exu_muldiv;
  // MULH, MULHSU, DIV and REM treat op1 as signed; MULH, DIV and REM also treat op2 as signed.
  assign w_op1_signed = (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                        (w_funct3 == 3'b100) || (w_funct3 == 3'b110);
  assign w_op2_signed = (w_funct3 == 3'b001) || (w_funct3 == 3'b100) ||
                        (w_funct3 == 3'b110);
  assign w_op1_neg    = w_op1_signed && w_op1[XLEN-1];
  assign w_op2_neg    = w_op2_signed && w_op2[XLEN-1];
  assign w_op1_mag    = w_op1_neg ? (~w_op1 + 1'b1) : w_op1;
  assign w_op2_mag    = w_op2_neg ? (~w_op2 + 1'b1) : w_op2;
  assign w_div_zero   = w_funct3[2] && (w_op2 == '0);
  assign w_div_ovf    = w_funct3[2] && !w_funct3[0] &&
                        (w_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_op2 == '1);
  // Divide-by-zero: the quotient is all ones and the remainder is the dividend.
  // Signed overflow: the quotient is the dividend and the remainder is zero.
  assign w_special_res = w_div_zero ? (w_funct3[1] ? w_op1 : '1)
                                    : (w_funct3[1] ? '0 : w_op1);

  // Restoring-division step on the {remainder, quotient} pair
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quo;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_dvsr;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_rem   = r_prod[2*XLEN-1:XLEN];
  assign w_quo   = r_prod[XLEN-1:0];
  assign w_shift = {w_rem, w_quo[XLEN-1]};
  assign w_dvsr  = {1'b0, r_mcand[XLEN-1:0]};
  assign w_ge    = (w_shift >= w_dvsr);
  assign w_diff  = w_shift - w_dvsr;

  // Loop exit condition
  logic w_early;
  logic w_calc_last;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = !r_funct3[2] && (r_mplier[XLEN-1:1] == '0);
`else
  assign w_early = 1'b0;
`endif
  assign w_calc_last = (r_cnt == CNT_W'(XLEN-1)) || w_early;

  // Sign fixup and result select
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod_s = r_neg_q ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_s  = r_neg_q ? (~w_quo + 1'b1) : w_quo;
  assign w_rem_s  = r_neg_r ? (~w_rem + 1'b1) : w_rem;

  // Pick the low or high product half, the quotient or the remainder from funct3
  always_comb begin
    w_fix_res = w_prod_s[XLEN-1:0];
    case (r_funct3)
      3'b000:         w_fix_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_fix_res = w_quo_s;
      default:        w_fix_res = w_rem_s;
    endcase
  end

  // FSM and iterative datapath; the result registers change only on entry to DONE
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= S_IDLE;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= w_funct3;
            r_rd     <= bus.rd_addr_i_idu2exu_muldiv;
            if (w_div_zero || w_div_ovf) begin
              r_rd_data <= w_special_res;
              r_rd_addr <= bus.rd_addr_i_idu2exu_muldiv;
              r_state   <= S_DONE;
            end else begin
              r_neg_q  <= w_op1_neg ^ w_op2_neg;
              r_neg_r  <= w_op1_neg;
              // A divide starts with remainder 0 and the dividend in the quotient slot.
              r_prod   <= w_funct3[2] ? {{XLEN{1'b0}}, w_op1_mag} : '0;
              r_mcand  <= w_funct3[2] ? {{XLEN{1'b0}}, w_op2_mag} : {{XLEN{1'b0}}, w_op1_mag};
              r_mplier <= w_op2_mag;
              r_cnt    <= '0;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_funct3[2]) begin
            r_prod <= {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]),
                       w_quo[XLEN-2:0], w_ge};
          end else begin
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_calc_last) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_rd_data <= w_fix_res;
          r_rd_addr <= r_rd;
          r_state   <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hold_flag_o_muldiv_ctrl = !rstn &&
                                       (w_accept || (r_state == S_CALC) || (r_state == S_FIXUP));
  assign bus.busy_o                  = (r_state != S_IDLE);
  assign bus.reg_wen_o_muldiv_regs   = (r_state == S_DONE) && (r_rd_addr != 5'd0);
  assign bus.rd_data_o_muldiv_regs   = r_rd_data;
  assign bus.rd_addr_o_muldiv_regs   = r_rd_addr;
  assign bus.dbg_state               = r_state;

endmodule
